button_event_mmio: RTL

- Input-side companion to the memory-mapped game RAM: the RAM drives button state to the display, this block brings physical button presses back to the processor.
- Synchronizes and debounces 16 raw button inputs, detects press edges, and queues button indices in a small event FIFO.
- Exposes the FIFO, a status word and live levels as three memory-mapped words read over the processor data-memory bus.
- Top level muxes `dataOut` using `hit`.

---
 rtl/button_event_mmio.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/button_event_mmio.sv
// Button event block for the processor data-memory bus.
// Synchronizes and debounces 16 raw buttons, turns debounced press edges into
// button-index events, and queues them in a small FIFO. The processor sees the
// block as three words: EVT (BASE_ADDR, read pops), STATUS (BASE_ADDR+1,
// write bit 9 clears overflow) and LEVEL (BASE_ADDR+2, debounced levels).
// Optional build macro RELEASE_EVENTS_EN also queues debounced releases,
// tagged with entry bit 4, serviced after all pending presses.
module button_event_mmio #(
    parameter int ADDRESS_WIDTH   = 12,
    parameter int DATA_WIDTH      = 32,
    parameter int BASE_ADDR       = 100,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              btn_raw,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic                     rEn,
    input  logic                     wEn,
    input  logic [DATA_WIDTH-1:0]    dataIn,
    output logic [DATA_WIDTH-1:0]    dataOut,
    output logic                     hit,
    output logic                     irq
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_FW = PTR_W + 1;

    localparam logic [CNT_W-1:0]         CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_FW-1:0]        DEPTH_VAL = CNT_FW'(FIFO_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] EVT_ADDR  = ADDRESS_WIDTH'(BASE_ADDR);
    localparam logic [ADDRESS_WIDTH-1:0] STAT_ADDR = ADDRESS_WIDTH'(BASE_ADDR + 1);
    localparam logic [ADDRESS_WIDTH-1:0] LVL_ADDR  = ADDRESS_WIDTH'(BASE_ADDR + 2);

    // Input path state
    logic [15:0]      sync_q1, sync_q2, level;
    logic [CNT_W-1:0] db_cnt [16];
    logic [15:0]      flip, rise;

    // Event arbitration state
    logic [15:0] press_pend, press_clr, grant_mask;
    logic        grant_valid;
    logic [3:0]  grant_idx;
    logic [4:0]  push_entry;

    // FIFO state
    logic [4:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_FW-1:0] count, count_next;
    logic              overflow;
    logic              fifo_empty, fifo_full;

    // Bus decode
    logic                  rd_evt, rd_stat, rd_lvl, rd_hit;
    logic                  pop, push, ovf_set, ovf_clr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  unused_data_bits;

    // A button flips when its synced value has disagreed with the debounced level for the full window
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
        flip = '0;
        for (int i = 0; i < 16; i++) begin
            flip[i] = (sync_q2[i] != level[i]) && (db_cnt[i] == CNT_MAX);
        end
    end

    assign rise = flip & ~level;

    // Two-flop synchronizer, debounce counters and debounced levels
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
            level   <= '0;
            for (int i = 0; i < 16; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
            level   <= level ^ flip;
            for (int i = 0; i < 16; i++) begin
                if (sync_q2[i] == level[i] || flip[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef RELEASE_EVENTS_EN
    logic [15:0] fall, rel_pend, rel_clr;
    logic        grant_rel;

    assign fall = flip & level;
`endif

    // Fixed-priority pick: lowest pending press first, then (optionally) lowest pending release
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
`ifdef RELEASE_EVENTS_EN
        grant_rel   = 1'b0;
`endif
        for (int i = 15; i >= 0; i--) begin
            if (press_pend[i]) begin
                grant_valid = 1'b1;
                grant_idx   = 4'(i);
            end
        end
`ifdef RELEASE_EVENTS_EN
        if (!grant_valid) begin
            for (int i = 15; i >= 0; i--) begin
                if (rel_pend[i]) begin
                    grant_valid = 1'b1;
                    grant_rel   = 1'b1;
                    grant_idx   = 4'(i);
                end
            end
        end
`endif
    end

    assign grant_mask = 16'd1 << grant_idx;

`ifdef RELEASE_EVENTS_EN
    assign press_clr  = (grant_valid && !grant_rel) ? grant_mask : '0;
    assign rel_clr    = (grant_valid && grant_rel) ? grant_mask : '0;
    assign push_entry = {grant_rel, grant_idx};

    // Release-pending bits: set on a debounced fall, cleared once offered to the FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            rel_pend <= '0;
        end else begin
            rel_pend <= (rel_pend & ~rel_clr) | fall;
        end
    end
`else
    assign press_clr  = grant_valid ? grant_mask : '0;
    assign push_entry = {1'b0, grant_idx};
`endif

    // Press-pending bits: a re-press before service merges into the one pending event
    always_ff @(posedge clk) begin
        if (reset) begin
            press_pend <= '0;
        end else begin
            press_pend <= (press_pend & ~press_clr) | rise;
        end
    end

    assign rd_evt  = rEn && (addr == EVT_ADDR);
    assign rd_stat = rEn && (addr == STAT_ADDR);
    assign rd_lvl  = rEn && (addr == LVL_ADDR);
    assign rd_hit  = rd_evt || rd_stat || rd_lvl;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_VAL);

    // A full FIFO still accepts a push when the same edge pops an entry
    assign pop     = rd_evt && !fifo_empty;
    assign push    = grant_valid && (!fifo_full || pop);
    assign ovf_set = grant_valid && fifo_full && !pop;
    assign ovf_clr = wEn && (addr == STAT_ADDR) && dataIn[9];

    assign unused_data_bits = ^{dataIn[DATA_WIDTH-1:10], dataIn[8:0]};

    // Occupancy after this edge
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointers, occupancy, sticky overflow (set beats clear) and the non-empty interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_next;
            overflow <= ovf_set || (overflow && !ovf_clr);
            irq      <= (count_next != '0);
        end
    end

    // Event storage
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
        if (push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    // Read-data mux for the three register words
    always_comb begin
        rd_data = '0;
        if (rd_evt && !fifo_empty) begin
            rd_data[31]  = 1'b1;
            rd_data[4:0] = fifo_mem[rd_ptr];
        end else if (rd_stat) begin
            rd_data[CNT_FW-1:0] = count;
            rd_data[8]          = fifo_full;
            rd_data[9]          = overflow;
        end else if (rd_lvl) begin
            rd_data[15:0] = level;
        end
    end

    // Registered bus response, one cycle after the read strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            dataOut <= '0;
            hit     <= 1'b0;
        end else begin
            dataOut <= rd_data;
            hit     <= rd_hit;
        end
    end

endmodule
